// File: rtl/data_mem_responder.sv
// Data-memory responder: stalls each load/store for LATENCY+1 cycles, then performs a byte, half or word
// access on an internal word array. Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into traps.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  DATA_MEM_READ,
   input  logic [2:0]  DATA_MEM_WRITE,
   input  logic [31:0] DATA_MEM_ADDR,
   input  logic [31:0] DATA_MEM_WRITE_DATA,
   output logic [31:0] DATA_MEM_READ_DATA,
   output logic        DATA_MEM_BUSYWAIT,
   output logic        DATA_MEM_MISALIGN
);

   // state  | meaning
   // IDLE   | waiting for a request; BUSYWAIT follows request valid
   // ACCESS | latched request counting down its latency
   // DONE   | result visible, stall released for one cycle
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [AW+1:0] addr_q;
   logic [3:0]    rd_ctrl_q;
   logic [2:0]    wr_ctrl_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          misalign_q;
   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          req_valid;
   logic          is_wr;
   logic          acc_byte;
   logic          acc_half;
   logic          acc_word;
   logic          acc_known;
   logic          ld_signed;
   logic [1:0]    lane;
   logic [AW-1:0] word_idx;
   logic [31:0]   cur_word;
   logic [31:0]   shifted;
   logic [31:0]   load_val;
   logic [31:0]   store_word;
   logic          trap_hit;
   logic          complete;
   logic          mem_we;
   logic          unused_addr;

   assign req_valid   = DATA_MEM_READ[3] | DATA_MEM_WRITE[2];
   assign unused_addr = ^DATA_MEM_ADDR[31:AW+2];

   // A write wins when both enables are set, so the access size comes from the write control.
   always_comb begin
      is_wr     = wr_ctrl_q[2];
      acc_byte  = 1'b0;
      acc_half  = 1'b0;
      acc_word  = 1'b0;
      ld_signed = 1'b0;
      if (is_wr) begin
         case (wr_ctrl_q[1:0])
            2'b00:   acc_byte = 1'b1;
            2'b01:   acc_half = 1'b1;
            2'b10:   acc_word = 1'b1;
            default: ;
         endcase
      end else begin
         case (rd_ctrl_q[2:0])
            3'b000: begin acc_byte = 1'b1; ld_signed = 1'b1; end
            3'b001: begin acc_half = 1'b1; ld_signed = 1'b1; end
            3'b010: acc_word = 1'b1;
            3'b100: acc_byte = 1'b1;
            3'b101: acc_half = 1'b1;
            default: ;
         endcase
      end
      acc_known = acc_byte | acc_half | acc_word;
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign trap_hit = (acc_half & addr_q[0]) | (acc_word & (addr_q[1:0] != 2'b00));
`else
   assign trap_hit = 1'b0;
`endif

   // Offending low bits are dropped; in trap builds the access is suppressed anyway.
   always_comb begin
      if (acc_word) begin
         lane = 2'b00;
      end else if (acc_half) begin
         lane = {addr_q[1], 1'b0};
      end else begin
         lane = addr_q[1:0];
      end
   end

   assign word_idx = addr_q[AW+1:2];
   assign cur_word = mem_q[word_idx];
   assign shifted  = cur_word >> {lane, 3'b000};

   always_comb begin
      load_val = 32'h0;
      if (acc_byte) begin
         load_val = ld_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      end else if (acc_half) begin
         load_val = ld_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      end else if (acc_word) begin
         load_val = cur_word;
      end
   end

   always_comb begin
      store_word = cur_word;
      if (acc_byte) begin
         store_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      end else if (acc_half) begin
         store_word[{lane, 3'b000} +: 16] = wdata_q[15:0];
      end else if (acc_word) begin
         store_word = wdata_q;
      end
   end

   assign complete = (state_q == S_ACCESS) && (cnt_q == '0);
   assign mem_we   = RESET & complete & is_wr & acc_known & ~trap_hit;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         rd_ctrl_q  <= '0;
         wr_ctrl_q  <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               misalign_q <= 1'b0;
               if (req_valid) begin
                  addr_q    <= DATA_MEM_ADDR[AW+1:0];
                  rd_ctrl_q <= DATA_MEM_READ;
                  wr_ctrl_q <= DATA_MEM_WRITE;
                  wdata_q   <= DATA_MEM_WRITE_DATA;
                  cnt_q     <= CNT_LOAD;
                  state_q   <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (cnt_q == '0) begin
                  state_q    <= S_DONE;
                  misalign_q <= trap_hit;
                  if (trap_hit) begin
                     rdata_q <= '0;
                  end else if (is_wr) begin
                     // A pure store leaves the previous load result in place.
                     if (rd_ctrl_q[3]) begin
                        rdata_q <= '0;
                     end
                  end else begin
                     rdata_q <= load_val;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_DONE: begin
               misalign_q <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: begin
               misalign_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   // Array contents survive reset; only the write strobe is gated by it.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[word_idx] <= store_word;
      end
   end

   assign DATA_MEM_BUSYWAIT  = (state_q == S_ACCESS) || ((state_q == S_IDLE) && req_valid);
   assign DATA_MEM_READ_DATA = rdata_q;
   assign DATA_MEM_MISALIGN  = misalign_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand-written stall/abort sequences,
// then random accesses checked against a byte-level memory model.
module tb_data_mem_responder;
   localparam int LAT   = 4;
   localparam int DEPTH = 256;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1100, LHU = 4'b1101, NORD = 4'b0000;
   localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110, NOWR = 3'b000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  mem_read;
   logic [2:0]  mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_busy;
   logic        mem_mis;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .CLK                 (clk),
      .RESET               (rst_n),
      .DATA_MEM_READ       (mem_read),
      .DATA_MEM_WRITE      (mem_write),
      .DATA_MEM_ADDR       (mem_addr),
      .DATA_MEM_WRITE_DATA (mem_wdata),
      .DATA_MEM_READ_DATA  (mem_rdata),
      .DATA_MEM_BUSYWAIT   (mem_busy),
      .DATA_MEM_MISALIGN   (mem_mis)
   );

   typedef struct {
      logic [3:0]  rd;
      logic [2:0]  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chk;
      logic [31:0] exp;
      logic        exp_mis;
   } vec_t;

   vec_t        tbl[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] ref_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit c, input logic [31:0] exp, input logic em);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.chk = c; v.exp = exp; v.exp_mis = em;
      tbl.push_back(v);
   endtask

   // Drive one request, count stall cycles, sample the DONE cycle.
   task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic mis,
                         output int busy_n);
      @(negedge clk);
      mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wdata;
      busy_n = 0;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (!mem_busy) break;
         busy_n++;
         @(negedge clk);
      end
      rdata = mem_rdata;
      mis   = mem_mis;
      mem_read = NORD; mem_write = NOWR; mem_addr = '0; mem_wdata = '0;
   endtask

   // Reference: memory as bytes, access size and extension taken straight from the opcode.
   task automatic model(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] exp_rd, output logic exp_mis);
      int     sz, widx, off;
      bit     sgn, known, mis;
      longint val;
      sz = 1; sgn = 0; known = 1;
      if (wr[2]) begin
         case (wr[1:0])
            2'd0: sz = 1;
            2'd1: sz = 2;
            2'd2: sz = 4;
            default: known = 0;
         endcase
      end else begin
         case (rd[2:0])
            3'd0: begin sz = 1; sgn = 1; end
            3'd1: begin sz = 2; sgn = 1; end
            3'd2: sz = 4;
            3'd4: sz = 1;
            3'd5: sz = 2;
            default: known = 0;
         endcase
      end
      widx = int'((addr / 4) % DEPTH);
      off  = int'(addr % 4);
      mis  = known && ((off % sz) != 0);
      exp_mis = TRAP && mis;
      if (mis && TRAP) begin
         ref_rdata = '0;
      end else begin
         if (mis) off = off - (off % sz);
         if (wr[2]) begin
            if (known)
               for (int b = 0; b < sz; b++) ref_mem[widx][8*(off+b) +: 8] = wdata[8*b +: 8];
            if (rd[3]) ref_rdata = '0;
         end else if (known) begin
            val = 0;
            for (int b = 0; b < sz; b++) val = val | (longint'(ref_mem[widx][8*(off+b) +: 8]) << (8*b));
            if (sgn && val[8*sz-1]) val = val - (longint'(1) << (8*sz));
            ref_rdata = val[31:0];
         end else begin
            ref_rdata = '0;
         end
      end
      exp_rd = ref_rdata;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdata, er, a;
      logic        mis, em;
      int          busy_n, op, idx;
      logic [3:0]  rd;
      logic [2:0]  wr;

      rst_n = 1'b0; mem_read = NORD; mem_write = NOWR; mem_addr = '0; mem_wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", {31'h0, mem_busy}, 32'h0);
      chk("reset_rdata", mem_rdata, 32'h0);
      chk("reset_mis", {31'h0, mem_mis}, 32'h0);
      rst_n = 1'b1;

      add(NORD, SW,   32'h10,  32'hDEADBEEF, 0, 32'h0, 0);
      add(LW,   NOWR, 32'h10,  32'h0, 1, 32'hDEADBEEF, 0);
      add(NORD, SW,   32'h10,  32'h11223344, 0, 32'h0, 0);
      add(NORD, SB,   32'h13,  32'hFFFFFF80, 0, 32'h0, 0);
      add(LW,   NOWR, 32'h10,  32'h0, 1, 32'h80223344, 0);
      add(LB,   NOWR, 32'h13,  32'h0, 1, 32'hFFFFFF80, 0);
      add(LBU,  NOWR, 32'h13,  32'h0, 1, 32'h00000080, 0);
      add(NORD, SW,   32'h20,  32'h0, 0, 32'h0, 0);
      add(NORD, SH,   32'h22,  32'h1234BEEF, 0, 32'h0, 0);
      add(LH,   NOWR, 32'h22,  32'h0, 1, 32'hFFFFBEEF, 0);
      add(LHU,  NOWR, 32'h22,  32'h0, 1, 32'h0000BEEF, 0);
      add(LW,   NOWR, 32'h20,  32'h0, 1, 32'hBEEF0000, 0);
      add(NORD, SW,   32'h404, 32'hCAFEF00D, 0, 32'h0, 0);
      add(LW,   NOWR, 32'h004, 32'h0, 1, 32'hCAFEF00D, 0);
      add(4'b1011, NOWR, 32'h10, 32'h0, 1, 32'h0, 0);
      add(LW,   SW,   32'h30,  32'h77, 1, 32'h0, 0);
      add(LW,   NOWR, 32'h30,  32'h0, 1, 32'h77, 0);
      add(NORD, SW,   32'h40,  32'h55, 0, 32'h0, 0);
      add(NORD, SW,   32'h42,  32'h99, TRAP, 32'h0, TRAP);
      add(LW,   NOWR, 32'h40,  32'h0, 1, TRAP ? 32'h55 : 32'h99, 0);
      add(LW,   NOWR, 32'h13,  32'h0, 1, TRAP ? 32'h0 : 32'h80223344, TRAP);
      add(LH,   NOWR, 32'h23,  32'h0, 1, TRAP ? 32'h0 : 32'hFFFFBEEF, TRAP);
      add(LHU,  NOWR, 32'h21,  32'h0, 1, 32'h0, TRAP);

      for (int i = 0; i < tbl.size(); i++) begin
         access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rdata, mis, busy_n);
         chk($sformatf("tbl%0d_busy_len", i), 32'(busy_n), 32'(LAT + 1));
         chk($sformatf("tbl%0d_mis", i), {31'h0, mis}, {31'h0, tbl[i].exp_mis});
         if (tbl[i].chk) chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp);
      end

      // Back-to-back loads with inputs held through DONE.
      @(negedge clk);
      mem_read = LW; mem_write = NOWR; mem_addr = 32'h10; mem_wdata = '0;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk($sformatf("b2b_busy_c%0d", k), {31'h0, mem_busy}, (k == 5 || k == 11) ? 32'h0 : 32'h1);
         if (k == 5 || k == 11) begin
            chk($sformatf("b2b_rdata_c%0d", k), mem_rdata, TRAP ? 32'h80223344 : 32'h80223344);
         end
         if (k == 11) begin
            mem_read = NORD; mem_addr = '0;
         end
         @(negedge clk);
      end

      // Reset in the middle of a store aborts it.
      access(NORD, SW, 32'h40, 32'h55, rdata, mis, busy_n);
      access(LW, NOWR, 32'h10, 32'h0, rdata, mis, busy_n);
      chk("abort_pre_rdata", rdata, 32'h80223344);
      @(negedge clk);
      mem_read = NORD; mem_write = SW; mem_addr = 32'h40; mem_wdata = 32'h1234;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      mem_write = NOWR; mem_addr = '0; mem_wdata = '0;
      @(negedge clk);
      #1;
      chk("abort_busy", {31'h0, mem_busy}, 32'h0);
      chk("abort_rdata", mem_rdata, 32'h0);
      rst_n = 1'b1;
      access(LW, NOWR, 32'h40, 32'h0, rdata, mis, busy_n);
      chk("abort_busy_len", 32'(busy_n), 32'(LAT + 1));
      chk("abort_word_kept", rdata, 32'h55);

      // Random accesses over a 16-word window, with random aliasing upper bits.
      ref_rdata = 32'h55;
      for (int w = 0; w < 16; w++) begin
         a = 32'((128 + w) * 4);
         model(NORD, SW, a, $urandom, er, em);
         access(NORD, SW, a, ref_mem[128 + w], rdata, mis, busy_n);
      end
      for (int t = 0; t < 300; t++) begin
         op  = $urandom_range(0, 9);
         idx = 128 + $urandom_range(0, 15);
         a   = {$urandom, 2'b00} & 32'hFFFF_FC00;
         a   = a | 32'(idx * 4) | 32'($urandom_range(0, 3));
         rd  = {1'b0, 3'($urandom_range(0, 7))};
         wr  = {1'b0, 2'($urandom_range(0, 3))};
         case (op)
            0: rd = LB;
            1: rd = LH;
            2: rd = LW;
            3: rd = LBU;
            4: rd = LHU;
            5: rd = {1'b1, ($urandom_range(0, 2) == 0) ? 3'b011 : ($urandom_range(0, 1) == 0 ? 3'b110 : 3'b111)};
            6: wr = SB;
            7: wr = SH;
            8: wr = SW;
            default: begin
               rd = {1'b1, 3'($urandom_range(0, 7))};
               wr = {1'b1, 2'($urandom_range(0, 2))};
            end
         endcase
         mem_wdata = '0;
         model(rd, wr, a, 32'(t * 32'h9E3779B1), er, em);
         access(rd, wr, a, 32'(t * 32'h9E3779B1), rdata, mis, busy_n);
         chk($sformatf("rnd%0d_busy_len", t), 32'(busy_n), 32'(LAT + 1));
         chk($sformatf("rnd%0d_mis", t), {31'h0, mis}, {31'h0, em});
         chk($sformatf("rnd%0d_rdata", t), rdata, er);
         repeat ($urandom_range(0, 1)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
